// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking duration/fee calculator.
package parking_pkg;

  localparam int DEF_TIME_W     = 8;
  localparam int DEF_DAY_TICKS  = 240;
  localparam int DEF_UNIT_TICKS = 15;
  localparam int DEF_RATE_W     = 8;
  localparam int DEF_FEE_W      = 16;

  // Controller states: capture, duration/validity, unit-by-unit billing, result hold
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIFF   = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/parking_duration_calc_if.sv
// Request/result handshake bundle for parking_duration_calc.
interface parking_duration_calc_if #(
  parameter int TIME_W = 8,
  parameter int RATE_W = 8,
  parameter int FEE_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [TIME_W-1:0] time_in;
  logic [TIME_W-1:0] time_out;
  logic [RATE_W-1:0] rate;
  logic              out_valid;
  logic              out_ready;
  logic [TIME_W-1:0] duration;
  logic [FEE_W-1:0]  fee;
  logic              err;

  // Producer of requests / consumer of results
  modport master (
    output in_valid, time_in, time_out, rate, out_ready,
    input  in_ready, out_valid, duration, fee, err
  );

  // The calculator itself
  modport slave (
    input  in_valid, time_in, time_out, rate, out_ready,
    output in_ready, out_valid, duration, fee, err
  );
endinterface

// File: rtl/parking_duration_calc_fee_accumulator.sv
// Billing datapath: walks the parked ticks down one unit per step and adds
// the rate to a fee that saturates at MAX_FEE.
module fee_accumulator #(
  parameter int                TIME_W     = 8,
  parameter int                UNIT_TICKS = 15,
  parameter int                RATE_W     = 8,
  parameter int                FEE_W      = 16,
  parameter logic [FEE_W-1:0]  MAX_FEE    = {FEE_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,   // start a new bill: remaining <= ticks, fee <= 0
  input  logic [TIME_W-1:0] i_ticks,
  input  logic              i_step,   // bill one (possibly partial) unit
  input  logic [RATE_W-1:0] i_rate,
  output logic              o_last,   // the current step brings remaining to zero
  output logic [FEE_W-1:0]  o_fee
);

  localparam int SUM_W = ((FEE_W > RATE_W) ? FEE_W : RATE_W) + 1;

  logic [TIME_W-1:0] r_remaining;
  logic [FEE_W-1:0]  r_fee;
  logic              w_last;
  logic [TIME_W-1:0] w_rem_next;
  logic [SUM_W-1:0]  w_sum;
  logic [FEE_W-1:0]  w_fee_next;

  // Unit-step subtract (a final partial unit counts as a whole one) and
  // saturating fee add; the sum is one bit wider so the ceiling test is exact.
  always_comb begin
    w_last     = (64'(r_remaining) <= 64'(UNIT_TICKS));
    w_rem_next = w_last ? '0 : (r_remaining - TIME_W'(UNIT_TICKS));
    w_sum      = SUM_W'(r_fee) + SUM_W'(i_rate);
    w_fee_next = (w_sum > SUM_W'(MAX_FEE)) ? MAX_FEE : w_sum[FEE_W-1:0];
  end

  // Remaining-ticks and fee registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remaining <= '0;
      r_fee       <= '0;
    end else if (i_load) begin
      r_remaining <= i_ticks;
      r_fee       <= '0;
    end else if (i_step) begin
      r_remaining <= w_rem_next;
      r_fee       <= w_fee_next;
    end
  end

  assign o_last = w_last;
  assign o_fee  = r_fee;

endmodule

// File: rtl/parking_duration_calc.sv
// Parking duration and fee calculator: captures entry/exit stamps, checks
// them against the day length, resolves overnight wrap, then bills one unit
// per cycle through fee_accumulator and holds the result until taken.
module parking_duration_calc
  import parking_pkg::*;
#(
  parameter int               TIME_W     = DEF_TIME_W,
  parameter int               DAY_TICKS  = DEF_DAY_TICKS,   // must be <= 2**TIME_W
  parameter int               UNIT_TICKS = DEF_UNIT_TICKS,  // must be >= 1
  parameter int               RATE_W     = DEF_RATE_W,
  parameter int               FEE_W      = DEF_FEE_W,
  parameter logic [FEE_W-1:0] MAX_FEE    = {FEE_W{1'b1}}
) (
  input  logic                    clk,
  input  logic                    reset,
  parking_duration_calc_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic [TIME_W-1:0] r_t_in;
  logic [TIME_W-1:0] r_t_out;
  logic [RATE_W-1:0] r_rate;
  logic [TIME_W-1:0] r_duration;
  logic              r_err;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_bad;
  logic [TIME_W:0]   w_wrap_base;
  logic [TIME_W-1:0] w_diff;
  logic [TIME_W-1:0] w_ticks;
  logic [FEE_W-1:0]  w_fee;

  // Stamp validity and duration. The wrap case forms DAY_TICKS - in first in
  // TIME_W+1 bits (DAY_TICKS may equal 2**TIME_W); the final sum is below
  // DAY_TICKS so it fits TIME_W bits.
  always_comb begin
    w_bad       = ({1'b0, r_t_in}  >= (TIME_W+1)'(DAY_TICKS)) ||
                  ({1'b0, r_t_out} >= (TIME_W+1)'(DAY_TICKS));
    w_wrap_base = (TIME_W+1)'(DAY_TICKS) - {1'b0, r_t_in};
    if (r_t_out >= r_t_in) w_diff = r_t_out - r_t_in;
    else                   w_diff = TIME_W'(w_wrap_base + {1'b0, r_t_out});
    w_ticks     = w_bad ? '0 : w_diff;
  end

  // Next state and handshake outputs
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = DIFF;
      end
      DIFF: begin
        w_load = 1'b1;
        w_next = (w_ticks == '0) ? DONE : DIVIDE;
      end
      DIVIDE: begin
        w_step = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, request capture and duration/error result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_t_in     <= '0;
      r_t_out    <= '0;
      r_rate     <= '0;
      r_duration <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_in_ready && bus.in_valid) begin
        r_t_in  <= bus.time_in;
        r_t_out <= bus.time_out;
        r_rate  <= bus.rate;
      end
      if (w_load) begin
        r_duration <= w_ticks;
        r_err      <= w_bad;
      end
    end
  end

  fee_accumulator #(
    .TIME_W    (TIME_W),
    .UNIT_TICKS(UNIT_TICKS),
    .RATE_W    (RATE_W),
    .FEE_W     (FEE_W),
    .MAX_FEE   (MAX_FEE)
  ) u_acc (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_ticks(w_ticks),
    .i_step (w_step),
    .i_rate (r_rate),
    .o_last (w_last),
    .o_fee  (w_fee)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.duration  = r_duration;
  assign bus.fee       = w_fee;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_parking_duration_calc.sv
// Directed bench: two calculators share stimulus, one with the default fee
// ceiling and one with MAX_FEE=1000, checked against hand-computed vectors.
module tb_parking_duration_calc;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  parking_duration_calc_if #(.TIME_W(8), .RATE_W(8), .FEE_W(16)) bus_a ();
  parking_duration_calc_if #(.TIME_W(8), .RATE_W(8), .FEE_W(16)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.time_in   = bus_a.time_in;
  assign bus_b.time_out  = bus_a.time_out;
  assign bus_b.rate      = bus_a.rate;
  assign bus_b.out_ready = bus_a.out_ready;

  parking_duration_calc dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  parking_duration_calc #(.MAX_FEE(16'd1000)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tin;
    logic [7:0]  tout;
    logic [7:0]  rate;
    logic [7:0]  dur;
    logic [15:0] fee_a;
    logic [15:0] fee_b;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a request, pass the accept edge, then count edges until out_valid
  // (accept edge counts as 1).
  task automatic start_and_wait(input logic [7:0] tin, input logic [7:0] tout,
                                input logic [7:0] rate, output int lat);
    bus_a.time_in  = tin;
    bus_a.time_out = tout;
    bus_a.rate     = rate;
    bus_a.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    lat = 1;
    while (!bus_a.out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0;
    chk({tag, " in_ready after release"}, longint'(bus_a.in_ready), 1);
    chk({tag, " out_valid after release"}, longint'(bus_a.out_valid), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    lat;
    string tag;
    tag = $sformatf("v%0d(%0d->%0d r%0d)", idx, v.tin, v.tout, v.rate);
    start_and_wait(v.tin, v.tout, v.rate, lat);
    chk({tag, " latency"},    longint'(lat),            longint'(v.lat));
    chk({tag, " b out_valid"},longint'(bus_b.out_valid),1);
    chk({tag, " duration"},   longint'(bus_a.duration), longint'(v.dur));
    chk({tag, " fee"},        longint'(bus_a.fee),      longint'(v.fee_a));
    chk({tag, " err"},        longint'(bus_a.err),      longint'(v.err));
    chk({tag, " b fee"},      longint'(bus_b.fee),      longint'(v.fee_b));
    chk({tag, " b duration"}, longint'(bus_b.duration), longint'(v.dur));
    release_result(tag);
  endtask

  initial begin
    int lat;

    //          tin  tout rate dur  fee_a  fee_b err lat
    vecs[0]  = '{8'd10,  8'd50,  8'd10,  8'd40,  16'd30,   16'd30,   1'b0, 5};
    vecs[1]  = '{8'd230, 8'd5,   8'd10,  8'd15,  16'd10,   16'd10,   1'b0, 3};
    vecs[2]  = '{8'd100, 8'd100, 8'd10,  8'd0,   16'd0,    16'd0,    1'b0, 2};
    vecs[3]  = '{8'd245, 8'd20,  8'd10,  8'd0,   16'd0,    16'd0,    1'b1, 2};
    vecs[4]  = '{8'd0,   8'd239, 8'd10,  8'd239, 16'd160,  16'd160,  1'b0, 18};
    vecs[5]  = '{8'd20,  8'd240, 8'd10,  8'd0,   16'd0,    16'd0,    1'b1, 2};
    vecs[6]  = '{8'd0,   8'd15,  8'd7,   8'd15,  16'd7,    16'd7,    1'b0, 3};
    vecs[7]  = '{8'd0,   8'd16,  8'd7,   8'd16,  16'd14,   16'd14,   1'b0, 4};
    vecs[8]  = '{8'd239, 8'd0,   8'd3,   8'd1,   16'd3,    16'd3,    1'b0, 3};
    vecs[9]  = '{8'd50,  8'd10,  8'd10,  8'd200, 16'd140,  16'd140,  1'b0, 16};
    vecs[10] = '{8'd0,   8'd239, 8'd255, 8'd239, 16'd4080, 16'd1000, 1'b0, 18};
    vecs[11] = '{8'd0,   8'd75,  8'd200, 8'd75,  16'd1000, 16'd1000, 1'b0, 7};
    vecs[12] = '{8'd0,   8'd76,  8'd200, 8'd76,  16'd1200, 16'd1000, 1'b0, 8};
    vecs[13] = '{8'd255, 8'd255, 8'd10,  8'd0,   16'd0,    16'd0,    1'b1, 2};

    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    bus_a.time_in   = '0;
    bus_a.time_out  = '0;
    bus_a.rate      = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset in_ready",  longint'(bus_a.in_ready),  1);
    chk("reset out_valid", longint'(bus_a.out_valid), 0);
    chk("reset duration",  longint'(bus_a.duration),  0);
    chk("reset fee",       longint'(bus_a.fee),       0);
    chk("reset err",       longint'(bus_a.err),       0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Back-pressure in DONE: outputs hold, new requests ignored; then a
    // release with in_valid still high must not re-accept on the same edge.
    start_and_wait(8'd10, 8'd50, 8'd10, lat);
    chk("hold latency", longint'(lat), 5);
    bus_a.time_in  = 8'd0;
    bus_a.time_out = 8'd200;
    bus_a.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d out_valid", c), longint'(bus_a.out_valid), 1);
      chk($sformatf("hold%0d in_ready", c),  longint'(bus_a.in_ready),  0);
      chk($sformatf("hold%0d duration", c),  longint'(bus_a.duration),  40);
      chk($sformatf("hold%0d fee", c),       longint'(bus_a.fee),       30);
      chk($sformatf("hold%0d err", c),       longint'(bus_a.err),       0);
    end
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0;
    chk("no re-accept in_ready", longint'(bus_a.in_ready),  1);
    chk("no re-accept out_valid",longint'(bus_a.out_valid), 0);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    chk("follow-on accepted", longint'(bus_a.in_ready), 0);
    lat = 1;
    while (!bus_a.out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("follow-on latency",  longint'(lat),            16);
    chk("follow-on duration", longint'(bus_a.duration), 200);
    chk("follow-on fee",      longint'(bus_a.fee),      140);
    release_result("follow-on");

    // Reset in the middle of DIVIDE discards the request.
    bus_a.time_in  = 8'd0;
    bus_a.time_out = 8'd239;
    bus_a.rate     = 8'd10;
    bus_a.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid-divide busy", longint'(bus_a.in_ready), 0);
    reset = 1'b1;
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_a.out_ready = 1'b0;
    chk("mid reset in_ready",  longint'(bus_a.in_ready),  1);
    chk("mid reset out_valid", longint'(bus_a.out_valid), 0);
    chk("mid reset duration",  longint'(bus_a.duration),  0);
    chk("mid reset fee",       longint'(bus_a.fee),       0);
    chk("mid reset err",       longint'(bus_a.err),       0);
    chk("mid reset b fee",     longint'(bus_b.fee),       0);

    run_vec(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parking_duration_calc.md
PARKING_DURATION_CALC -- requirements
Module: parking_duration_calc

Interface
REQ-001 Parameter TIME_W, default 8, SHALL set the bit width of the time-stamp inputs and the duration output.
REQ-002 Parameter DAY_TICKS, default 240, SHALL set the time-stamp modulus (ticks per day); it SHALL satisfy DAY_TICKS <= 2**TIME_W.
REQ-003 Parameter UNIT_TICKS, default 15, SHALL set the billing unit in ticks; it SHALL be at least 1.
REQ-004 Parameter RATE_W, default 8, SHALL set the width of the per-unit rate input.
REQ-005 Parameter FEE_W, default 16, SHALL set the width of the fee output.
REQ-006 Parameter MAX_FEE, default 2**FEE_W-1, SHALL set the fee saturation ceiling.
REQ-007 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-008 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-009 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-010 Port in_valid, input, 1 bit, SHALL indicate that a request is present.
REQ-011 Port in_ready, output, 1 bit, SHALL indicate that the block can accept a request.
REQ-012 Port time_in, input, TIME_W bits, SHALL carry the entry time-stamp.
REQ-013 Port time_out, input, TIME_W bits, SHALL carry the exit time-stamp.
REQ-014 Port rate, input, RATE_W bits, SHALL carry the fee per started billing unit.
REQ-015 Port out_valid, output, 1 bit, SHALL indicate that a result is held on the outputs.
REQ-016 Port out_ready, input, 1 bit, SHALL indicate that the consumer accepts the result.
REQ-017 Port duration, output, TIME_W bits, SHALL carry the parked ticks.
REQ-018 Port fee, output, FEE_W bits, SHALL carry the saturated fee.
REQ-019 Port err, output, 1 bit, SHALL flag an out-of-range time-stamp.

Function
REQ-020 The FSM SHALL have states IDLE, DIFF, DIVIDE and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-021 In IDLE, a cycle with in_valid=1 SHALL register time_in, time_out and rate and move to DIFF; inputs in other states SHALL be ignored.
REQ-022 In DIFF, if time_in >= DAY_TICKS or time_out >= DAY_TICKS, the block SHALL set err=1, duration=0 and fee=0, and move to DONE.
REQ-023 In DIFF with valid inputs, duration SHALL be time_out - time_in when time_out >= time_in.
REQ-024 Otherwise duration SHALL be DAY_TICKS - time_in + time_out (overnight wrap), computed without intermediate overflow.
REQ-025 In DIFF with valid inputs, units SHALL be set to ceil(duration/UNIT_TICKS) by the first DIVIDE step, and fee SHALL be cleared.
REQ-026 DIFF SHALL go to DONE when duration=0, and to DIVIDE otherwise.
REQ-027 Each DIVIDE cycle SHALL subtract min(UNIT_TICKS, remaining) from the remaining ticks and add rate to fee, saturating at MAX_FEE.
REQ-028 DIVIDE SHALL go to DONE in the cycle in which remaining reaches 0.
REQ-029 out_valid SHALL rise N+2 cycles after the accept edge, where N = units (0 for zero duration or error).
REQ-030 In DONE, duration, fee and err SHALL hold stable while out_ready=0.
REQ-031 In DONE with out_ready=1, the block SHALL return to IDLE on the next edge; there SHALL be no same-cycle re-accept.
REQ-032 Once fee saturates, it SHALL remain at MAX_FEE and DIVIDE SHALL still run to completion, so latency is unchanged.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL go to IDLE with in_ready=1, out_valid=0, duration=0, fee=0, err=0 and internal counters cleared.
REQ-034 Reset SHALL have this effect in any state, including mid-DIVIDE and DONE; any in-flight request SHALL be discarded.
REQ-035 Reset SHALL take priority over in_valid and out_ready.

Structure
REQ-036 Shared package parking_pkg SHALL hold the FSM state enum and the default parameter constants (TIME_W, DAY_TICKS, UNIT_TICKS).
REQ-037 Sub-module fee_accumulator SHALL hold the unit-step subtractor and the saturating fee adder; parking_duration_calc SHALL hold the FSM, handshake and wrap logic.

Verification (defaults, rate=10)
REQ-038 in=10, out=50 -> duration=40, fee=30, err=0, out_valid 5 cycles after accept.
REQ-039 in=230, out=5 -> duration=15, fee=10 (overnight wrap).
REQ-040 in=out=100 -> duration=0, fee=0, out_valid 2 cycles after accept.
REQ-041 in=245, out=20 -> err=1, duration=0, fee=0.
REQ-042 MAX_FEE=1000, rate=255, in=0, out=239 -> 16 units, fee=1000, out_valid 18 cycles after accept.
REQ-043 out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0; reset asserted mid-DIVIDE -> next cycle IDLE with all outputs 0.
